// File: rtl/sum_accumulator_pkg.sv
// ============================================================================
// Module : sum_accumulator_pkg
// Brief  : Shared widths, state encoding and state type for sum_accumulator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sum_accumulator_pkg;

    localparam int unsigned c_BW_DATA = 4;
    localparam int unsigned c_BW_ACC  = 8;
    localparam int unsigned c_BW_LEN  = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_ACC  = S_ACC,
        ST_DONE = S_DONE
    } state_e;

endpackage

`default_nettype wire

// File: rtl/sat_adder.sv
// ============================================================================
// Module : sat_adder
// Brief  : Combinational unsigned add that clamps to all-ones on carry-out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_adder #(
    parameter int BW_ACC = 8
) (
    input  logic [BW_ACC-1:0] i_acc,
    input  logic [BW_ACC-1:0] i_smp,
    output logic [BW_ACC-1:0] o_sum,
    output logic              o_ovf
);

    logic [BW_ACC:0] w_full;

    assign w_full = {1'b0, i_acc} + {1'b0, i_smp};
    assign o_ovf  = w_full[BW_ACC];
    assign o_sum  = o_ovf ? {BW_ACC{1'b1}} : w_full[BW_ACC-1:0];

endmodule

`default_nettype wire

// File: rtl/sum_accumulator.sv
// ============================================================================
// Module : sum_accumulator
// Brief  : Accumulates a programmed count of adder samples into a saturating
//          total and presents it on a valid/ready result port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int BW_DATA = c_BW_DATA,
    parameter int BW_ACC  = c_BW_ACC,
    parameter int BW_LEN  = c_BW_LEN
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [BW_DATA-1:0] i_y,
    input  logic               i_y_vld,
    input  logic               i_start,
    input  logic [BW_LEN-1:0]  i_len,
    output logic [BW_ACC-1:0]  o_acc,
    output logic               o_acc_vld,
    input  logic               i_acc_rdy,
    output logic               o_sat,
    output logic               o_busy
);

    localparam logic [BW_LEN-1:0] c_ONE = BW_LEN'(1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [BW_LEN-1:0]   r_cnt;
    logic [BW_LEN-1:0]   r_len;
    logic [BW_ACC-1:0]   r_acc;
    logic                r_sat;
    logic [BW_ACC-1:0]   w_smp_ext;
    logic [BW_ACC-1:0]   w_sum;
    logic                w_ovf;
    logic                w_last;

    assign w_smp_ext = BW_ACC'(i_y);
    assign w_last    = (r_cnt == (r_len - c_ONE));

    sat_adder #(
        .BW_ACC (BW_ACC)
    ) u_sat_adder (
        .i_acc  (r_acc),
        .i_smp  (w_smp_ext),
        .o_sum  (w_sum),
        .o_ovf  (w_ovf)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A zero-length job skips ACC and reports the cleared total directly.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_start)           w_state_nxt = (i_len != '0) ? ST_ACC : ST_DONE;
            ST_ACC:  if (i_y_vld && w_last) w_state_nxt = ST_DONE;
            ST_DONE: if (i_acc_rdy)         w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt <= '0;
            r_len <= '0;
            r_acc <= '0;
            r_sat <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_len <= i_len;
                        r_cnt <= '0;
                        r_acc <= '0;
                        r_sat <= 1'b0;
                    end
                end
                ST_ACC: begin
                    if (i_y_vld) begin
                        r_acc <= w_sum;
                        r_sat <= r_sat | w_ovf;
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_acc     = r_acc;
    assign o_sat     = r_sat;
    assign o_acc_vld = (r_state == ST_DONE);
    assign o_busy    = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sum_accumulator.sv
// ============================================================================
// Module : tb_sum_accumulator
// Brief  : Self-checking bench for sum_accumulator with a plain-arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sum_accumulator;

    localparam int BW_DATA = 4;
    localparam int BW_ACC  = 6;
    localparam int BW_LEN  = 4;
    localparam int ACC_MAX = (1 << BW_ACC) - 1;

    logic               clk;
    logic               rstn;
    logic [BW_DATA-1:0] y;
    logic               y_vld;
    logic               start;
    logic [BW_LEN-1:0]  len;
    logic [BW_ACC-1:0]  acc;
    logic               acc_vld;
    logic               acc_rdy;
    logic               sat;
    logic               busy;

    int n_run;
    int n_fail;

    sum_accumulator #(
        .BW_DATA (BW_DATA),
        .BW_ACC  (BW_ACC),
        .BW_LEN  (BW_LEN)
    ) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_y       (y),
        .i_y_vld   (y_vld),
        .i_start   (start),
        .i_len     (len),
        .o_acc     (acc),
        .o_acc_vld (acc_vld),
        .i_acc_rdy (acc_rdy),
        .o_sat     (sat),
        .o_busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int n);
        start = 1'b1;
        len   = BW_LEN'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int v);
        y     = BW_DATA'(v);
        y_vld = 1'b1;
        tick();
        y_vld = 1'b0;
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        y       = BW_DATA'($urandom);
        y_vld   = 1'($urandom);
        start   = 1'b1;
        len     = BW_LEN'($urandom);
        acc_rdy = 1'($urandom);
        #3;
        for (int c = 0; c < 3; c++) begin
            n_run++;
            if ({acc, acc_vld, sat, busy} !== '0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: acc=%0d vld=%b sat=%b busy=%b, want all 0", c, acc, acc_vld, sat, busy);
            end
            tick();
            y = BW_DATA'($urandom); y_vld = 1'($urandom);
        end
        y = '0; y_vld = 0; start = 0; len = '0; acc_rdy = 0;
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        acc_rdy = 1'b1;
        launch(3);
        n_run++;
        if (busy !== 1'b1 || acc_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_start: busy=%b vld=%b, want busy=1 vld=0", busy, acc_vld);
        end
        feed(1);
        feed(2);
        n_run++;
        if (acc_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early_vld: vld=%b, want 0", acc_vld);
        end
        feed(3);
        n_run++;
        if (acc_vld !== 1'b1 || acc !== 6 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: vld=%b acc=%0d sat=%b, want 1/6/0", acc_vld, acc, sat);
        end
        tick();
        n_run++;
        if (acc_vld !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: vld=%b busy=%b, want 0/0", acc_vld, busy);
        end
        acc_rdy = 1'b0;
    endtask

    task automatic test_gapped();
        launch(2);
        feed(5);
        for (int g = 0; g < 3; g++) begin
            tick();
            n_run++;
            if (acc_vld !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL gap%0d: vld=%b busy=%b, want 0/1", g, acc_vld, busy);
            end
        end
        feed(7);
        n_run++;
        if (acc_vld !== 1'b1 || acc !== 12 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL gapped_result: vld=%b acc=%0d sat=%b, want 1/12/0", acc_vld, acc, sat);
        end
        acc_rdy = 1'b1;
        tick();
        acc_rdy = 1'b0;
        n_run++;
        if (acc_vld !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL gapped_idle: vld=%b busy=%b, want 0/0", acc_vld, busy);
        end
    endtask

    task automatic test_saturation();
        acc_rdy = 1'b1;
        launch(5);
        for (int k = 0; k < 5; k++) feed(15);
        n_run++;
        if (acc_vld !== 1'b1 || acc !== ACC_MAX || sat !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_result: vld=%b acc=%0d sat=%b, want 1/%0d/1", acc_vld, acc, sat, ACC_MAX);
        end
        tick();
        launch(1);
        feed(2);
        n_run++;
        if (acc_vld !== 1'b1 || acc !== 2 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_clear: vld=%b acc=%0d sat=%b, want 1/2/0", acc_vld, acc, sat);
        end
        tick();
        acc_rdy = 1'b0;
    endtask

    task automatic test_backpressure();
        launch(2);
        feed(4);
        feed(6);
        for (int c = 0; c < 4; c++) begin
            start = (c == 1);
            len   = 4'd3;
            y     = 4'd9;
            y_vld = 1'b1;
            n_run++;
            if (acc_vld !== 1'b1 || acc !== 10 || sat !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: vld=%b acc=%0d sat=%b busy=%b, want 1/10/0/1", c, acc_vld, acc, sat, busy);
            end
            tick();
        end
        start = 1'b0; y_vld = 1'b0;
        acc_rdy = 1'b1;
        n_run++;
        if (acc_vld !== 1'b1 || acc !== 10) begin
            n_fail++;
            $display("FAIL bp_last: vld=%b acc=%0d, want 1/10", acc_vld, acc);
        end
        tick();
        acc_rdy = 1'b0;
        tick();
        n_run++;
        if (acc_vld !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_new_job: vld=%b busy=%b, want 0/0", acc_vld, busy);
        end
    endtask

    task automatic test_len_zero();
        launch(0);
        n_run++;
        if (acc_vld !== 1'b1 || acc !== 0 || sat !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL len0: vld=%b acc=%0d sat=%b busy=%b, want 1/0/0/1", acc_vld, acc, sat, busy);
        end
        acc_rdy = 1'b1;
        tick();
        acc_rdy = 1'b0;
        n_run++;
        if (acc_vld !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_idle: vld=%b busy=%b, want 0/0", acc_vld, busy);
        end
    endtask

    task automatic test_reset_midjob();
        acc_rdy = 1'b1;
        launch(4);
        feed(3);
        feed(5);
        #2 rstn = 1'b0;
        #1;
        n_run++;
        if ({acc, acc_vld, sat, busy} !== '0) begin
            n_fail++;
            $display("FAIL midjob_reset: acc=%0d vld=%b sat=%b busy=%b, want all 0", acc, acc_vld, sat, busy);
        end
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            y = BW_DATA'(c + 1);
            y_vld = 1'b1;
            tick();
            n_run++;
            if (acc_vld !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset%0d: vld=%b busy=%b, want 0/0", c, acc_vld, busy);
            end
        end
        y_vld = 1'b0;
        acc_rdy = 1'b0;
    endtask

    task automatic test_random();
        for (int j = 0; j < 25; j++) begin
            int n;
            int total;
            int exp_acc;
            bit exp_sat;
            bit early;
            n     = $urandom_range(0, 15);
            early = 1'($urandom);
            total = 0;
            acc_rdy = early;
            launch(n);
            for (int k = 0; k < n; k++) begin
                int gaps;
                int v;
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    y = BW_DATA'($urandom);
                    tick();
                    n_run++;
                    if (acc_vld !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rnd%0d_gap: vld=%b, want 0", j, acc_vld);
                    end
                end
                v = $urandom_range(0, 15);
                total += v;
                feed(v);
            end
            exp_acc = (total > ACC_MAX) ? ACC_MAX : total;
            exp_sat = (total > ACC_MAX);
            n_run++;
            if (acc_vld !== 1'b1 || acc !== BW_ACC'(exp_acc) || sat !== exp_sat) begin
                n_fail++;
                $display("FAIL rnd%0d_result len=%0d: vld=%b acc=%0d sat=%b, want 1/%0d/%b", j, n, acc_vld, acc, sat, exp_acc, exp_sat);
            end
            if (!early) begin
                int w;
                w = $urandom_range(0, 3);
                for (int c = 0; c < w; c++) begin
                    y = BW_DATA'($urandom);
                    y_vld = 1'($urandom);
                    tick();
                    n_run++;
                    if (acc_vld !== 1'b1 || acc !== BW_ACC'(exp_acc)) begin
                        n_fail++;
                        $display("FAIL rnd%0d_hold: vld=%b acc=%0d, want 1/%0d", j, acc_vld, acc, exp_acc);
                    end
                end
                y_vld = 1'b0;
                acc_rdy = 1'b1;
            end
            tick();
            acc_rdy = 1'b0;
            n_run++;
            if (acc_vld !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd%0d_idle: vld=%b busy=%b, want 0/0", j, acc_vld, busy);
            end
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rstn = 1'b0; y = '0; y_vld = 0; start = 0; len = '0; acc_rdy = 0;
        test_reset();
        test_basic();
        test_gapped();
        test_saturation();
        test_backpressure();
        test_len_zero();
        test_reset_midjob();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the registered operand-adder stage. Accepts the adder's BW_DATA-bit sum stream under a sample-valid strobe and accumulates a programmed number of samples into a wider saturating accumulator. Presents the final total through a valid/ready output handshake, then returns to idle for the next job. Sits between the adder pipeline and the result-collection logic.

## Interface
- BW_DATA, 4: width of incoming sum samples; must equal the adder stage's data width.
- BW_ACC, 8: accumulator/result width; must be >= BW_DATA.
- BW_LEN, 4: width of sample-count field.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_y  in  BW_DATA  sum sample from adder stage (unsigned).
- i_y_vld  in  1  sample valid; top level drives it as the adder input-valid delayed one cycle.
- i_start  in  1  job start pulse; sampled only in IDLE.
- i_len  in  BW_LEN  number of samples in job; sampled with i_start.
- o_acc  out  BW_ACC  accumulated result; registered.
- o_acc_vld  out  1  result valid.
- i_acc_rdy  in  1  result consumer ready.
- o_sat  out  1  result saturated flag; qualifies o_acc.
- o_busy  out  1  high in ACC and DONE.

## Operation
- States: IDLE, ACC, DONE.
- IDLE:
  - i_y_vld ignored.
  - i_start=1: latch i_len, clear acc/cnt/sat.
  - Next state ACC if i_len!=0, else DONE with o_acc=0, o_sat=0.
- ACC:
  - Each cycle with i_y_vld=1: acc <= sat_add(acc, zero-extend(i_y)); cnt++.
  - On the valid sample where cnt==len-1: go DONE.
  - Cycles with i_y_vld=0 hold all state.
- DONE:
  - o_acc_vld=1; o_acc and o_sat held stable.
  - i_acc_rdy=1: handshake completes, next state IDLE, o_acc_vld drops.
- i_start in ACC or DONE ignored (no queueing); i_y_vld in DONE ignored (samples dropped).
- Arithmetic:
  - Sum computed at BW_ACC+1 bits.
  - If bit BW_ACC is set, acc <= 2^BW_ACC-1 and o_sat <= 1.
  - o_sat is sticky until the next job start.
- cnt width is BW_LEN; max job = 2^BW_LEN-1 samples; no wrap possible.

## Timing
- Reset: state=IDLE; o_acc=0, o_acc_vld=0, o_sat=0, o_busy=0; internal cnt/len=0.
- Reset asserted mid-job aborts it immediately (async); no partial result is emitted.
- o_busy rises the cycle after the i_start acceptance edge.
- Result latency: o_acc_vld rises on the edge that registers the last sample (visible the cycle after the last i_y_vld).
- len=0: o_acc_vld=1 one cycle after start.
- Handshake:
  - Transfer on the edge where o_acc_vld & i_acc_rdy.
  - i_acc_rdy may be high before o_acc_vld; in that case DONE lasts exactly one cycle.
- Minimum job turnaround: one IDLE cycle between the handshake and the next start acceptance.

## Structure
- Shared package sum_accumulator_pkg:
  - state encoding localparams S_IDLE=2'd0, S_ACC=2'd1, S_DONE=2'd2.
  - default width constants.
- Sub-module sat_adder: combinational, parameterised BW_ACC; inputs acc and extended sample; outputs saturated sum and overflow bit.
- Top: FSM, counter, length register, output registers.

## Test plan
- Reset: assert i_rstn=0 with random inputs -> o_acc=0, o_acc_vld=0, o_sat=0, o_busy=0.
- Basic job: start len=3, back-to-back samples 1,2,3, i_acc_rdy=1 -> o_acc_vld one cycle after the sample 3 cycle, o_acc=6, o_sat=0, then IDLE.
- Gapped samples: len=2, sample 5, then i_y_vld=0 for 3 cycles, then sample 7 -> o_acc=12; gaps add no latency beyond the final sample.
- Saturation (BW_ACC=6): len=5, all samples 15 -> o_acc=63, o_sat=1; next job len=1 sample 2 -> o_acc=2, o_sat=0.
- Backpressure and ignored inputs:
  - Hold i_acc_rdy=0 for 4 cycles in DONE, and pulse i_start plus i_y_vld=1 with value 9 meanwhile.
  - Required: o_acc stable, o_acc_vld held, no new job started; after i_acc_rdy=1, IDLE.
- Edge cases: start len=0 -> o_acc_vld with o_acc=0 one cycle later; start len=4, deassert i_rstn after 2 samples -> all outputs 0, and no o_acc_vld after reset release.
